// File: rtl/rv32i_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control unit: FSM states,
// major opcodes, ALU decoder commands and datapath mux encodings.
package rv32i_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXER,
        S_EXEI,
        S_LUI,
        S_AUIPC,
        S_ALUWB,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_BRANCH,
        S_JAL,
        S_JALR_ADR,
        S_JALR_LINK,
        S_ILLEGAL
    } ctrl_state_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // funct3 of SRLI/SRAI: the only immediate ALU op where funct7[5] matters
    localparam logic [2:0] F3_SHIFT_RIGHT = 3'b101;

endpackage

// File: rtl/rv32i_multicycle_ctrl_branch_cond.sv
// Branch condition evaluation: maps funct3 and the datapath comparison
// flags to a taken decision, flagging the two unused funct3 codes.
module branch_cond (
    input  logic [2:0] funct3,
    input  logic       alu_zero,
    input  logic       alu_lt,
    input  logic       alu_ltu,
    output logic       taken,
    output logic       illegal
);

    // Select the comparison flag (or its inverse) named by funct3
    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            3'b000:  taken = alu_zero;
            3'b001:  taken = !alu_zero;
            3'b100:  taken = alu_lt;
            3'b101:  taken = !alu_lt;
            3'b110:  taken = alu_ltu;
            3'b111:  taken = !alu_ltu;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/rv32i_multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core. Sequences the shared ALU
// and the single memory port, and counts retired instructions.
// Optional feature macro: ILLEGAL_TRAP_EN (sticky trap on illegal opcodes,
// FSM parks until reset). Without it an illegal opcode is a one-cycle NOP.
module rv32i_multicycle_ctrl
    import rv32i_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             alu_zero,
    input  logic             alu_lt,
    input  logic             alu_ltu,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             adr_src,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             alu_f7_kill,
    output logic [1:0]       result_src,
    output logic             instr_retired,
    output logic [CNT_W-1:0] instret
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic             trap
`endif
);

    ctrl_state_t state;
    logic        br_taken;
    logic        br_illegal;

    branch_cond u_branch_cond (
        .funct3   (funct3),
        .alu_zero (alu_zero),
        .alu_lt   (alu_lt),
        .alu_ltu  (alu_ltu),
        .taken    (br_taken),
        .illegal  (br_illegal)
    );

    // State sequencing; the trap flag is set on the same edge that enters ILLEGAL
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
`ifdef ILLEGAL_TRAP_EN
            trap  <= 1'b0;
`endif
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_ready) state <= S_DECODE;
                end
                S_DECODE: begin
                    case (opcode)
                        OP_RTYPE:          state <= S_EXER;
                        OP_ITYPE:          state <= S_EXEI;
                        OP_LOAD, OP_STORE: state <= S_MEMADR;
                        OP_BRANCH:         state <= S_BRANCH;
                        OP_JAL:            state <= S_JAL;
                        OP_JALR:           state <= S_JALR_ADR;
                        OP_LUI:            state <= S_LUI;
                        OP_AUIPC:          state <= S_AUIPC;
                        default: begin
                            state <= S_ILLEGAL;
`ifdef ILLEGAL_TRAP_EN
                            trap  <= 1'b1;
`endif
                        end
                    endcase
                end
                S_EXER, S_EXEI, S_LUI, S_AUIPC, S_JAL, S_JALR_LINK: begin
                    state <= S_ALUWB;
                end
                S_ALUWB, S_MEMWB: begin
                    state <= S_FETCH;
                end
                S_MEMADR: begin
                    state <= (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: begin
                    if (mem_ready) state <= S_MEMWB;
                end
                S_MEMWR: begin
                    if (mem_ready) state <= S_FETCH;
                end
                S_BRANCH: begin
                    if (br_illegal) begin
                        state <= S_ILLEGAL;
`ifdef ILLEGAL_TRAP_EN
                        trap  <= 1'b1;
`endif
                    end else begin
                        state <= S_FETCH;
                    end
                end
                S_JALR_ADR: begin
                    state <= S_JALR_LINK;
                end
                S_ILLEGAL: begin
`ifdef ILLEGAL_TRAP_EN
                    state <= S_ILLEGAL;
`else
                    state <= S_FETCH;
`endif
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

    // Datapath controls decoded from the state; memory handshakes add the Mealy terms
    always_comb begin
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        adr_src       = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALUOP_ADD;
        alu_f7_kill   = 1'b0;
        result_src    = RES_ALUOUT;
        instr_retired = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                alu_op     = ALUOP_ADD;
                result_src = RES_ALURESULT;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ADD;
            end
            S_EXER: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXEI: begin
                alu_src_a   = SRCA_RS1;
                alu_src_b   = SRCB_IMM;
                alu_op      = ALUOP_FUNCT;
                alu_f7_kill = (funct3 != F3_SHIFT_RIGHT);
            end
            S_LUI: begin
                alu_src_a = SRCA_ZERO;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ADD;
            end
            S_AUIPC: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ADD;
            end
            S_ALUWB: begin
                result_src    = RES_ALUOUT;
                reg_write     = 1'b1;
                instr_retired = 1'b1;
            end
            S_MEMADR, S_JALR_ADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                adr_src  = 1'b1;
                mem_read = 1'b1;
            end
            S_MEMWB: begin
                result_src    = RES_MEMDATA;
                reg_write     = 1'b1;
                instr_retired = 1'b1;
            end
            S_MEMWR: begin
                adr_src       = 1'b1;
                mem_write     = 1'b1;
                instr_retired = mem_ready;
            end
            S_BRANCH: begin
                alu_src_a     = SRCA_RS1;
                alu_src_b     = SRCB_RS2;
                alu_op        = ALUOP_SUB;
                result_src    = RES_ALUOUT;
                pc_write      = br_taken;
                instr_retired = !br_illegal;
            end
            S_JAL, S_JALR_LINK: begin
                result_src = RES_ALUOUT;
                pc_write   = 1'b1;
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                alu_op     = ALUOP_ADD;
            end
            default: begin
            end
        endcase
    end

    // Retired-instruction counter; reset takes priority over a retiring cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            instret <= '0;
        end else if (instr_retired) begin
            instret <= instret + 1'b1;
        end
    end

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Self-checking bench for rv32i_multicycle_ctrl. Each instruction pushes its
// expected per-cycle control vector to a scoreboard queue; the drain loop
// pops one entry per cycle, drives its inputs and compares the DUT outputs.
// Works with or without ILLEGAL_TRAP_EN defined.
module tb_rv32i_multicycle_ctrl;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             alu_zero;
    logic             alu_lt;
    logic             alu_ltu;
    logic             mem_ready;
    logic             pc_write;
    logic             ir_write;
    logic             adr_src;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             alu_f7_kill;
    logic [1:0]       result_src;
    logic             instr_retired;
    logic [CNT_W-1:0] instret;
`ifdef ILLEGAL_TRAP_EN
    logic             trap;
`endif

    rv32i_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .funct3        (funct3),
        .alu_zero      (alu_zero),
        .alu_lt        (alu_lt),
        .alu_ltu       (alu_ltu),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .ir_write      (ir_write),
        .adr_src       (adr_src),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .alu_f7_kill   (alu_f7_kill),
        .result_src    (result_src),
        .instr_retired (instr_retired),
        .instret       (instret)
`ifdef ILLEGAL_TRAP_EN
        ,
        .trap          (trap)
`endif
    );

    always #5 clk = ~clk;

    // Observed control vector, same bit order as mk() below
    logic [15:0] obs;
    assign obs = {pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
                  alu_src_a, alu_src_b, alu_op, alu_f7_kill, result_src, instr_retired};

    typedef struct {
        string       tag;
        logic [15:0] outs;
        logic        ready;
        logic        trapExp;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        z;
        logic        lt;
        logic        ltu;
    } exp_t;

    exp_t             expQ[$];
    int               compCount = 0;
    int               failCount = 0;
    logic [CNT_W-1:0] cntModel  = '0;

    string      curName;
    logic [6:0] curOp;
    logic [2:0] curF3;
    logic       curZ, curLt, curLtu;

    function automatic logic [15:0] mk(input logic pcw, input logic irw, input logic adr,
                                       input logic mrd, input logic mwr, input logic rw,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] op, input logic kill,
                                       input logic [1:0] res, input logic ret);
        return {pcw, irw, adr, mrd, mwr, rw, a, b, op, kill, res, ret};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic pushExp(input string st, input logic [15:0] outs, input logic ready, input logic trapExp);
        exp_t e;
        e.tag     = {curName, "/", st};
        e.outs    = outs;
        e.ready   = ready;
        e.trapExp = trapExp;
        e.op      = curOp;
        e.f3      = curF3;
        e.z       = curZ;
        e.lt      = curLt;
        e.ltu     = curLtu;
        expQ.push_back(e);
    endtask

    task automatic pushIllegal();
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) pushExp("ILLEGAL", 16'h0000, 1'b1, 1'b1);
`else
        pushExp("ILLEGAL", 16'h0000, 1'b1, 1'b0);
`endif
    endtask

    // Pop one expectation per cycle, drive its inputs, compare away from the edge
    task automatic drain();
        exp_t e;
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            @(negedge clk);
            opcode    = e.op;
            funct3    = e.f3;
            alu_zero  = e.z;
            alu_lt    = e.lt;
            alu_ltu   = e.ltu;
            mem_ready = e.ready;
            #1;
            checkOutput({e.tag, " ctrl"}, {16'h0, obs}, {16'h0, e.outs});
            checkOutput({e.tag, " instret"}, instret, cntModel);
`ifdef ILLEGAL_TRAP_EN
            checkOutput({e.tag, " trap"}, {31'h0, trap}, {31'h0, e.trapExp});
`endif
            if (e.outs[0]) cntModel++;
        end
    endtask

    // Build the expected cycle sequence of one instruction from its encoding, then run it
    task automatic applyStimulus(input string name, input logic [31:0] instr,
                                 input logic z, input logic lt, input logic ltu,
                                 input int nWait, input logic noComplete);
        logic       taken;
        logic       brIll;
        logic [15:0] aluwb;
        curName = name;
        curOp   = instr[6:0];
        curF3   = instr[14:12];
        curZ    = z;
        curLt   = lt;
        curLtu  = ltu;
        aluwb   = mk(0,0,0,0,0,1, 2'b00,2'b00,2'b00,0,2'b00,1);
        pushExp("FETCH",  mk(1,1,0,1,0,0, 2'b00,2'b10,2'b00,0,2'b10,0), 1'b1, 1'b0);
        pushExp("DECODE", mk(0,0,0,0,0,0, 2'b01,2'b01,2'b00,0,2'b00,0), 1'b1, 1'b0);
        case (curOp)
            7'b0110011: begin
                pushExp("EXER", mk(0,0,0,0,0,0, 2'b10,2'b00,2'b10,0,2'b00,0), 1'b1, 1'b0);
                pushExp("ALUWB", aluwb, 1'b1, 1'b0);
            end
            7'b0010011: begin
                pushExp("EXEI", mk(0,0,0,0,0,0, 2'b10,2'b01,2'b10,(curF3 != 3'b101),2'b00,0), 1'b1, 1'b0);
                pushExp("ALUWB", aluwb, 1'b1, 1'b0);
            end
            7'b0110111: begin
                pushExp("LUI", mk(0,0,0,0,0,0, 2'b11,2'b01,2'b00,0,2'b00,0), 1'b1, 1'b0);
                pushExp("ALUWB", aluwb, 1'b1, 1'b0);
            end
            7'b0010111: begin
                pushExp("AUIPC", mk(0,0,0,0,0,0, 2'b01,2'b01,2'b00,0,2'b00,0), 1'b1, 1'b0);
                pushExp("ALUWB", aluwb, 1'b1, 1'b0);
            end
            7'b0000011: begin
                pushExp("MEMADR", mk(0,0,0,0,0,0, 2'b10,2'b01,2'b00,0,2'b00,0), 1'b1, 1'b0);
                for (int i = 0; i < nWait; i++)
                    pushExp("MEMRD-wait", mk(0,0,1,1,0,0, 2'b00,2'b00,2'b00,0,2'b00,0), 1'b0, 1'b0);
                pushExp("MEMRD", mk(0,0,1,1,0,0, 2'b00,2'b00,2'b00,0,2'b00,0), 1'b1, 1'b0);
                pushExp("MEMWB", mk(0,0,0,0,0,1, 2'b00,2'b00,2'b00,0,2'b01,1), 1'b1, 1'b0);
            end
            7'b0100011: begin
                pushExp("MEMADR", mk(0,0,0,0,0,0, 2'b10,2'b01,2'b00,0,2'b00,0), 1'b1, 1'b0);
                for (int i = 0; i < nWait; i++)
                    pushExp("MEMWR-wait", mk(0,0,1,0,1,0, 2'b00,2'b00,2'b00,0,2'b00,0), 1'b0, 1'b0);
                if (!noComplete)
                    pushExp("MEMWR", mk(0,0,1,0,1,0, 2'b00,2'b00,2'b00,0,2'b00,1), 1'b1, 1'b0);
            end
            7'b1100011: begin
                taken = 1'b0;
                brIll = 1'b0;
                case (curF3)
                    3'b000:  taken = z;
                    3'b001:  taken = !z;
                    3'b100:  taken = lt;
                    3'b101:  taken = !lt;
                    3'b110:  taken = ltu;
                    3'b111:  taken = !ltu;
                    default: brIll = 1'b1;
                endcase
                pushExp("BRANCH", mk(taken,0,0,0,0,0, 2'b10,2'b00,2'b01,0,2'b00,!brIll), 1'b1, 1'b0);
                if (brIll) pushIllegal();
            end
            7'b1101111: begin
                pushExp("JAL", mk(1,0,0,0,0,0, 2'b01,2'b10,2'b00,0,2'b00,0), 1'b1, 1'b0);
                pushExp("ALUWB", aluwb, 1'b1, 1'b0);
            end
            7'b1100111: begin
                pushExp("JALR_ADR", mk(0,0,0,0,0,0, 2'b10,2'b01,2'b00,0,2'b00,0), 1'b1, 1'b0);
                pushExp("JALR_LINK", mk(1,0,0,0,0,0, 2'b01,2'b10,2'b00,0,2'b00,0), 1'b1, 1'b0);
                pushExp("ALUWB", aluwb, 1'b1, 1'b0);
            end
            default: pushIllegal();
        endcase
        drain();
    endtask

    // Synchronous reset: outputs must match FETCH with no memory ready
    task automatic doReset(input string name);
        @(negedge clk);
        rst       = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput({name, " ctrl"}, {16'h0, obs}, {16'h0, mk(0,0,0,1,0,0, 2'b00,2'b10,2'b00,0,2'b10,0)});
        checkOutput({name, " instret"}, instret, 32'h0);
`ifdef ILLEGAL_TRAP_EN
        checkOutput({name, " trap"}, {31'h0, trap}, 32'h0);
`endif
        rst      = 1'b0;
        cntModel = '0;
    endtask

    initial begin
        rst       = 1'b1;
        opcode    = 7'h00;
        funct3    = 3'h0;
        alu_zero  = 1'b0;
        alu_lt    = 1'b0;
        alu_ltu   = 1'b0;
        mem_ready = 1'b0;
        $display("[TB] start");

        doReset("reset");

        applyStimulus("ADD",      32'h002081B3, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        applyStimulus("ADDI",     32'h02008093, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        applyStimulus("SRAI",     32'h4010D093, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        applyStimulus("LW",       32'h0000A103, 1'b0, 1'b0, 1'b0, 3, 1'b0);
        applyStimulus("BNE-z1",   32'h00209463, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        applyStimulus("BNE-z0",   32'h00209463, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        applyStimulus("BLTU",     32'h0020E463, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        applyStimulus("SW",       32'h0020A023, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        applyStimulus("JAL",      32'h008000EF, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        applyStimulus("JALR",     32'h000080E7, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        applyStimulus("LUI",      32'h123450B7, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        applyStimulus("AUIPC",    32'h00001097, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        applyStimulus("OP7F",     32'h0000007F, 1'b0, 1'b0, 1'b0, 0, 1'b0);
`ifdef ILLEGAL_TRAP_EN
        doReset("trap-reset1");
`endif
        applyStimulus("BR-F3-010", 32'h0020A063, 1'b0, 1'b0, 1'b0, 0, 1'b0);
`ifdef ILLEGAL_TRAP_EN
        doReset("trap-reset2");
`endif

        // Store stalled by memory, then reset lands during the wait
        applyStimulus("SW-rst",   32'h0020A023, 1'b0, 1'b0, 1'b0, 2, 1'b1);
        @(negedge clk);
        rst       = 1'b1;
        mem_ready = 1'b0;
        #1;
        checkOutput("SW-rst/MEMWR-at-rst ctrl", {16'h0, obs},
                    {16'h0, mk(0,0,1,0,1,0, 2'b00,2'b00,2'b00,0,2'b00,0)});
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("SW-rst/after-rst ctrl", {16'h0, obs},
                    {16'h0, mk(0,0,0,1,0,0, 2'b00,2'b10,2'b00,0,2'b10,0)});
        checkOutput("SW-rst/after-rst instret", instret, 32'h0);
        cntModel = '0;

        applyStimulus("ADD-again", 32'h002081B3, 1'b0, 1'b0, 1'b0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
        $finish;
    end

endmodule
